traffic_sensor_conditioner: RTL and testbench
=============================================

TRAFFIC_SENSOR_CONDITIONER -- requirements
Module: traffic_sensor_conditioner

Interface
REQ-001 Parameter DEB_CYCLES, default 4, SHALL set the consecutive stable samples needed to qualify arrival or departure (legal range 1..15).
REQ-002 Parameter STUCK_CYCLES, default 1000, SHALL set the continuous-presence limit (in cycles) before a detector is declared stuck (range 2..65535).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 det_a, det_b  input  1 each  raw vehicle-loop detectors for street A/B, asynchronous to clk, may bounce.
REQ-006 Ga, Gb  input  1 each  green indications fed back from the light controller.
REQ-007 Sa, Sb  output  1 each  conditioned traffic-demand signals to the light controller.
REQ-008 stuck_a, stuck_b  output  1 each  sticky stuck-detector fault flags.
REQ-009 cnt_a, cnt_b  output  8 each  qualified vehicle-arrival counts.

Function
REQ-010 Each detector SHALL pass through a 2-flop synchronizer before any other use.
REQ-011 Each approach SHALL run an independent FSM with states ABSENT, ARRIVING, PRESENT, LEAVING.
REQ-012 ABSENT: synchronized input high -> ARRIVING, debounce count = 1; else stay.
REQ-013 ARRIVING: input high -> increment count, enter PRESENT when count reaches DEB_CYCLES; input low -> ABSENT, count cleared.
REQ-014 PRESENT: input low -> LEAVING, count = 1; else stay.
REQ-015 LEAVING: input low -> increment count, enter ABSENT when count reaches DEB_CYCLES; input high -> PRESENT, count cleared.
REQ-016 With DEB_CYCLES = 1, ARRIVING and LEAVING SHALL last exactly one cycle.
REQ-017 A demand latch per approach SHALL be set on the ARRIVING->PRESENT transition and cleared on any cycle with Gx = 1 and the FSM in ABSENT; set has priority.
REQ-018 Sx SHALL be decoded from registered state only: Sx = (state is PRESENT or LEAVING) OR latch OR stuck_x.
REQ-019 Latency: det_x first sampled high at edge 1 and held -> Sx high after edge 2+DEB_CYCLES (edge 6 at default); release is symmetric, but the latch keeps Sx high until the green clears it.
REQ-020 A presence counter SHALL count cycles in PRESENT/LEAVING, cleared in ABSENT; on reaching STUCK_CYCLES, stuck_x SHALL set and remain set until reset.
REQ-021 The presence counter SHALL saturate at STUCK_CYCLES and never wrap.
REQ-022 The A and B paths SHALL share no state; simultaneous events on both are processed in the same cycle.

Reset
REQ-023 Reset SHALL clear synchronizers, debounce and presence counters, latches, stuck flags and cnt_x, and SHALL put both FSMs in ABSENT; Sa = Sb = 0 after the reset edge.
REQ-024 Reset asserted mid-operation SHALL take effect at the next edge regardless of FSM state or Gx.

Configuration
REQ-025 Macro TRAFFIC_SENSOR_COUNT_EN defined: cnt_x SHALL increment by 1 on each ARRIVING->PRESENT transition and saturate at 255.
REQ-026 Macro TRAFFIC_SENSOR_COUNT_EN undefined: no counter logic SHALL be built and cnt_a = cnt_b = 0 constantly.

Structure
REQ-027 Shared package traffic_pkg SHALL hold the detector FSM state encoding, default DEB_CYCLES/STUCK_CYCLES constants and the count width (8).
REQ-028 Sub-module tl_detector_channel (synchronizer, FSM, latch, stuck logic, counter) SHALL be instantiated twice.

Verification
REQ-029 det_a held high from edge 1, DEB_CYCLES=4 -> Sa = 1 after edge 6, cnt_a = 1; Sb stays 0.
REQ-030 det_b pulses high for 3 cycles, then low -> Sb never asserts, cnt_b = 0.
REQ-031 det_a asserted 10 cycles then released, Ga = 0 throughout -> Sa stays 1; Ga pulsed 1 for one cycle after FSM reaches ABSENT -> Sa = 0 on the next edge.
REQ-032 det_b held high, STUCK_CYCLES=20 -> stuck_b = 1 after the 20th presence cycle; det_b released -> stuck_b and Sb remain 1 until reset.
REQ-033 300 qualified arrivals on A with count enabled -> cnt_a = 255; reset asserted while in PRESENT -> Sa = 0, cnt_a = 0 at the next edge.

Source files
------------

// File: rtl/traffic_pkg.sv
// ---------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the traffic sensor conditioner:
//   - det_state_t : per-approach detector FSM state encoding
//   - DEB_CYCLES_DEF / STUCK_CYCLES_DEF : default debounce / stuck limits
//   - CNT_W  : width of the qualified-arrival counters (8)
//   - DEB_W  : width of the debounce counter (holds 1..15)
//   - PRES_W : width of the presence counter (holds 2..65535)
//   - cnt_sat_inc() : saturating increment used by the arrival counter
// ---------------------------------------------------------------------------
package traffic_pkg;

  typedef enum logic [1:0] {
    DET_ABSENT   = 2'd0,
    DET_ARRIVING = 2'd1,
    DET_PRESENT  = 2'd2,
    DET_LEAVING  = 2'd3
  } det_state_t;

  localparam int DEB_CYCLES_DEF   = 4;
  localparam int STUCK_CYCLES_DEF = 1000;

  localparam int CNT_W  = 8;
  localparam int DEB_W  = 4;
  localparam int PRES_W = 16;

  // Increment that sticks at all-ones instead of wrapping to zero.
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end
    return v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/tl_detector_channel.sv
// ---------------------------------------------------------------------------
// tl_detector_channel
// One approach of the traffic sensor conditioner: 2-flop synchronizer,
// debounce FSM (ABSENT/ARRIVING/PRESENT/LEAVING), demand latch, stuck
// detector with sticky fault flag, and an optional qualified-arrival counter.
//
// Optional feature: define TRAFFIC_SENSOR_COUNT_EN to build the saturating
// arrival counter; otherwise cnt is tied to zero and no counter exists.
//
// Parameters
//   DEB_CYCLES   : consecutive stable samples to qualify a change (1..15)
//   STUCK_CYCLES : continuous presence cycles before stuck is flagged (2..65535)
// Ports
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset
//   det    in   raw loop detector (asynchronous, may bounce)
//   green  in   green indication for this approach
//   demand out  conditioned demand to the light controller
//   stuck  out  sticky stuck-detector flag
//   cnt    out  qualified arrival count (zero when the counter is not built)
// ---------------------------------------------------------------------------
module tl_detector_channel
  import traffic_pkg::*;
#(
  parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
  parameter int STUCK_CYCLES = STUCK_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             det,
  input  logic             green,
  output logic             demand,
  output logic             stuck,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [DEB_W:0]    DEB_LIM     = (DEB_W + 1)'(DEB_CYCLES);
  localparam logic [PRES_W-1:0] PRES_LIM    = PRES_W'(STUCK_CYCLES);
  localparam logic [PRES_W-1:0] PRES_LIM_M1 = PRES_W'(STUCK_CYCLES - 1);

  logic [1:0]        sync_reg;
  det_state_t        state_reg;
  logic [DEB_W-1:0]  deb_cnt_reg;
  logic              latch_reg;
  logic              stuck_reg;
  logic [PRES_W-1:0] pres_reg;

  logic [DEB_W:0]    deb_inc;
  logic              det_s;
  logic              deb_done;
  logic              arrive_qual;
  logic              in_presence;

  assign det_s       = sync_reg[1];
  // One bit wider than the counter so the +1 never wraps before the compare.
  assign deb_inc     = {1'b0, deb_cnt_reg} + {{DEB_W{1'b0}}, 1'b1};
  // ">=" rather than "==": with DEB_CYCLES = 1 the first qualifying sample
  // still spends one cycle in ARRIVING/LEAVING before the state flips.
  assign deb_done    = (deb_inc >= DEB_LIM);
  assign arrive_qual = (state_reg == DET_ARRIVING) && det_s && deb_done;
  assign in_presence = (state_reg == DET_PRESENT) || (state_reg == DET_LEAVING);

  // Demand is a pure decode of registered state, so it is glitch-free.
  assign demand = in_presence | latch_reg | stuck_reg;
  assign stuck  = stuck_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg    <= 2'b00;
      state_reg   <= DET_ABSENT;
      deb_cnt_reg <= '0;
      latch_reg   <= 1'b0;
      stuck_reg   <= 1'b0;
      pres_reg    <= '0;
    end else begin
      sync_reg <= {sync_reg[0], det};

      case (state_reg)
        DET_ABSENT: begin
          if (det_s) begin
            state_reg   <= DET_ARRIVING;
            deb_cnt_reg <= DEB_W'(1);
          end
        end
        DET_ARRIVING: begin
          if (!det_s) begin
            state_reg   <= DET_ABSENT;
            deb_cnt_reg <= '0;
          end else if (deb_done) begin
            state_reg   <= DET_PRESENT;
            deb_cnt_reg <= '0;
          end else begin
            deb_cnt_reg <= deb_inc[DEB_W-1:0];
          end
        end
        DET_PRESENT: begin
          if (!det_s) begin
            state_reg   <= DET_LEAVING;
            deb_cnt_reg <= DEB_W'(1);
          end
        end
        DET_LEAVING: begin
          if (det_s) begin
            state_reg   <= DET_PRESENT;
            deb_cnt_reg <= '0;
          end else if (deb_done) begin
            state_reg   <= DET_ABSENT;
            deb_cnt_reg <= '0;
          end else begin
            deb_cnt_reg <= deb_inc[DEB_W-1:0];
          end
        end
        default: begin
          state_reg   <= DET_ABSENT;
          deb_cnt_reg <= '0;
        end
      endcase

      // Demand latch: a qualified arrival is remembered until the approach
      // has been served (green) while the loop reads empty. Set wins.
      if (arrive_qual) begin
        latch_reg <= 1'b1;
      end else if (green && (state_reg == DET_ABSENT)) begin
        latch_reg <= 1'b0;
      end

      // Presence counter: counts continuous occupied cycles, saturates at the
      // stuck limit. ARRIVING only follows ABSENT, so the counter is already
      // zero there and is simply held.
      if (in_presence) begin
        if (pres_reg != PRES_LIM) begin
          pres_reg <= pres_reg + PRES_W'(1);
        end
        if (pres_reg >= PRES_LIM_M1) begin
          stuck_reg <= 1'b1;
        end
      end else if (state_reg == DET_ABSENT) begin
        pres_reg <= '0;
      end
    end
  end

`ifdef TRAFFIC_SENSOR_COUNT_EN
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (arrive_qual) begin
      cnt_reg <= cnt_sat_inc(cnt_reg);
    end
  end

  assign cnt = cnt_reg;
`else
  assign cnt = '0;
`endif

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// ---------------------------------------------------------------------------
// traffic_sensor_conditioner
// Conditions the two raw vehicle-loop detectors (streets A and B) into clean
// demand signals for the light controller. Each street is handled by its own
// tl_detector_channel instance; the two channels share no state.
//
// Optional feature: define TRAFFIC_SENSOR_COUNT_EN to build the 8-bit
// saturating qualified-arrival counters; otherwise cnt_a = cnt_b = 0.
//
// Parameters
//   DEB_CYCLES   : debounce length in samples (1..15, default 4)
//   STUCK_CYCLES : presence limit before a stuck fault (2..65535, default 1000)
// Ports
//   clk              in   rising-edge clock
//   reset            in   synchronous active-high reset
//   det_a, det_b     in   raw detectors (asynchronous, may bounce)
//   Ga, Gb           in   green indications from the light controller
//   Sa, Sb           out  conditioned demand
//   stuck_a, stuck_b out  sticky stuck-detector flags
//   cnt_a, cnt_b     out  qualified arrival counts (8 bit)
// ---------------------------------------------------------------------------
module traffic_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
  parameter int STUCK_CYCLES = STUCK_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             det_a,
  input  logic             det_b,
  input  logic             Ga,
  input  logic             Gb,
  output logic             Sa,
  output logic             Sb,
  output logic             stuck_a,
  output logic             stuck_b,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  localparam int NUM_CH = 2;

  // Index 0 = street A, index 1 = street B.
  logic [NUM_CH-1:0] det_v;
  logic [NUM_CH-1:0] green_v;
  logic [NUM_CH-1:0] demand_v;
  logic [NUM_CH-1:0] stuck_v;
  logic [CNT_W-1:0]  cnt_v [NUM_CH];

  assign det_v   = {det_b, det_a};
  assign green_v = {Gb, Ga};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
      tl_detector_channel #(
        .DEB_CYCLES   (DEB_CYCLES),
        .STUCK_CYCLES (STUCK_CYCLES)
      ) u_chan (
        .clk    (clk),
        .reset  (reset),
        .det    (det_v[gi]),
        .green  (green_v[gi]),
        .demand (demand_v[gi]),
        .stuck  (stuck_v[gi]),
        .cnt    (cnt_v[gi])
      );
    end
  endgenerate

  assign Sa      = demand_v[0];
  assign Sb      = demand_v[1];
  assign stuck_a = stuck_v[0];
  assign stuck_b = stuck_v[1];
  assign cnt_a   = cnt_v[0];
  assign cnt_b   = cnt_v[1];

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// ---------------------------------------------------------------------------
// tb_traffic_sensor_conditioner
// Directed stimulus with a run-length behavioural model: an approach becomes
// "occupied" after DEB consecutive synchronized samples opposite to its
// current qualified value. Outputs are checked every cycle on the falling
// edge, plus hand-computed literal expectations at key points.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_traffic_sensor_conditioner;

  localparam int DEB   = 4;
  localparam int STUCK = 20;
`ifdef TRAFFIC_SENSOR_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       det_a = 1'b0;
  logic       det_b = 1'b0;
  logic       Ga    = 1'b0;
  logic       Gb    = 1'b0;
  logic       Sa, Sb, stuck_a, stuck_b;
  logic [7:0] cnt_a, cnt_b;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  traffic_sensor_conditioner #(
    .DEB_CYCLES   (DEB),
    .STUCK_CYCLES (STUCK)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .det_a   (det_a),
    .det_b   (det_b),
    .Ga      (Ga),
    .Gb      (Gb),
    .Sa      (Sa),
    .Sb      (Sb),
    .stuck_a (stuck_a),
    .stuck_b (stuck_b),
    .cnt_a   (cnt_a),
    .cnt_b   (cnt_b)
  );

  // ---------------- behavioural model ----------------
  bit m_s1[2], m_s2[2], m_q[2], m_latch[2], m_stuck[2];
  int m_run[2], m_pres[2], m_cnt[2];
  bit m_d, m_g, m_rise, m_wabs, m_wocc;

  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      m_d = (c == 0) ? det_a : det_b;
      m_g = (c == 0) ? Ga : Gb;
      if (reset) begin
        m_s1[c] = 0; m_s2[c] = 0; m_q[c] = 0; m_run[c] = 0;
        m_latch[c] = 0; m_stuck[c] = 0; m_pres[c] = 0; m_cnt[c] = 0;
      end else begin
        m_wabs = !m_q[c] && (m_run[c] == 0);
        m_wocc = m_q[c];
        m_rise = 0;
        if (m_s2[c] != m_q[c]) begin
          m_run[c]++;
          if (m_run[c] >= DEB) begin
            m_q[c]   = m_s2[c];
            m_run[c] = 0;
            m_rise   = m_q[c];
          end
        end else begin
          m_run[c] = 0;
        end
        m_s2[c] = m_s1[c];
        m_s1[c] = m_d;
        if (m_rise) m_latch[c] = 1;
        else if (m_g && m_wabs) m_latch[c] = 0;
        if (m_wocc) m_pres[c] = (m_pres[c] < STUCK) ? m_pres[c] + 1 : STUCK;
        else if (m_wabs) m_pres[c] = 0;
        if (m_pres[c] >= STUCK) m_stuck[c] = 1;
        if (m_rise && CNT_EN && m_cnt[c] < 255) m_cnt[c]++;
      end
    end
  end

  function automatic int exp_s(input int c);
    return int'(m_q[c] | m_latch[c] | m_stuck[c]);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("Sa",      int'(Sa),      exp_s(0));
      chk("Sb",      int'(Sb),      exp_s(1));
      chk("stuck_a", int'(stuck_a), int'(m_stuck[0]));
      chk("stuck_b", int'(stuck_b), int'(m_stuck[1]));
      chk("cnt_a",   int'(cnt_a),   m_cnt[0]);
      chk("cnt_b",   int'(cnt_b),   m_cnt[1]);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  logic [15:0] bounce_pat;

  initial begin
    reset = 1'b1;
    cyc(3);
    chk_en = 1'b1;
    chk("rst_Sa", int'(Sa), 0);
    chk("rst_Sb", int'(Sb), 0);
    chk("rst_stuck_a", int'(stuck_a), 0);
    chk("rst_cnt_a", int'(cnt_a), 0);
    reset = 1'b0;
    cyc(2);
    $display("step reset: Sa=%0d Sb=%0d", Sa, Sb);

    // Arrival on A: sampled high at edge 1, demand after edge 6.
    det_a = 1'b1;
    cyc(5);
    chk("arr_Sa_edge5", int'(Sa), 0);
    cyc(1);
    chk("arr_Sa_edge6", int'(Sa), 1);
    chk("arr_model_edge6", exp_s(0), 1);
    chk("arr_Sb_edge6", int'(Sb), 0);
    chk("arr_cnt_a", int'(cnt_a), CNT_EN ? 1 : 0);
    $display("step arrival A: Sa=%0d cnt_a=%0d", Sa, cnt_a);

    // Held 10 cycles, released; latch holds Sa until green while absent.
    cyc(4);
    det_a = 1'b0;
    cyc(8);
    chk("latch_Sa_held", int'(Sa), 1);
    Ga = 1'b1;
    cyc(1);
    Ga = 1'b0;
    chk("latch_Sa_cleared", int'(Sa), 0);
    $display("step green clear A: Sa=%0d", Sa);

    // Short pulse on B never qualifies.
    det_b = 1'b1;
    cyc(3);
    det_b = 1'b0;
    cyc(10);
    chk("pulse_Sb", int'(Sb), 0);
    chk("pulse_cnt_b", int'(cnt_b), 0);
    $display("step short pulse B: Sb=%0d", Sb);

    // Bouncing A with runs of at most 3 never qualifies.
    bounce_pat = 16'b0111_0110_1110_1101;
    for (int i = 0; i < 16; i++) begin
      det_a = bounce_pat[i];
      cyc(1);
    end
    det_a = 1'b0;
    cyc(4);
    chk("bounce_Sa", int'(Sa), 0);
    $display("step bounce A: Sa=%0d", Sa);

    // Departure interrupted: LEAVING falls back to PRESENT.
    det_a = 1'b1; cyc(8);
    det_a = 1'b0; cyc(2);
    det_a = 1'b1; cyc(4);
    det_a = 1'b0; cyc(10);
    chk("leavebounce_Sa", int'(Sa), 1);
    Ga = 1'b1; cyc(1); Ga = 1'b0;
    chk("leavebounce_clr", int'(Sa), 0);
    $display("step leave bounce A: Sa=%0d", Sa);

    // Stuck detector on B.
    det_b = 1'b1;
    cyc(25);
    chk("stuck_b_before", int'(stuck_b), 0);
    cyc(1);
    chk("stuck_b_set", int'(stuck_b), 1);
    det_b = 1'b0;
    cyc(20);
    Gb = 1'b1; cyc(2); Gb = 1'b0;
    chk("stuck_b_sticky", int'(stuck_b), 1);
    chk("stuck_Sb_sticky", int'(Sb), 1);
    $display("step stuck B: stuck_b=%0d Sb=%0d", stuck_b, Sb);
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    chk("stuck_b_reset", int'(stuck_b), 0);
    chk("Sb_reset", int'(Sb), 0);

    // 300 arrivals on A, 150 simultaneous arrivals on B.
    for (int i = 0; i < 300; i++) begin
      det_a = 1'b1;
      det_b = (i % 2 == 1);
      cyc(7);
      det_a = 1'b0;
      det_b = 1'b0;
      cyc(7);
    end
    chk("sat_cnt_a", int'(cnt_a), CNT_EN ? 255 : 0);
    chk("sat_cnt_b", int'(cnt_b), CNT_EN ? 150 : 0);
    $display("step 300 arrivals: cnt_a=%0d cnt_b=%0d", cnt_a, cnt_b);

    // Reset while PRESENT with green active.
    det_a = 1'b1;
    cyc(7);
    chk("pre_rst_Sa", int'(Sa), 1);
    reset = 1'b1;
    Ga = 1'b1;
    cyc(1);
    chk("midrst_Sa", int'(Sa), 0);
    chk("midrst_cnt_a", int'(cnt_a), 0);
    reset = 1'b0;
    Ga = 1'b0;
    det_a = 1'b0;
    cyc(12);
    $display("step mid reset: Sa=%0d cnt_a=%0d", Sa, cnt_a);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
